// File: rtl/handshake_rr_arbiter_if.sv
// Requester-side and downstream 4-phase channels of handshake_rr_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface handshake_rr_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32
);
   logic [N_REQ-1:0]        req_i;
   logic [N_REQ-1:0]        ack_i;
   logic [N_REQ*DATA_W-1:0] data_i;
   logic                    req_o;
   logic                    ack_o;
   logic [DATA_W-1:0]       data_o;
   logic [N_REQ-1:0]        grant_o;
   logic                    busy_o;
   logic                    err_o;

   modport slave (
      input  req_i, data_i, ack_o,
      output ack_i, req_o, data_o, grant_o, busy_o, err_o
   );

   modport master (
      output req_i, data_i, ack_o,
      input  ack_i, req_o, data_o, grant_o, busy_o, err_o
   );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one downstream 4-phase req/ack channel among N_REQ requesters.
// The winner's word is latched at grant time; its upstream handshake closes only after the downstream one.
module handshake_rr_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   handshake_rr_arbiter_if.slave bus
);
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;
   localparam logic [1:0] ST_RET  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  gnt_q, gnt_d;
   logic              req_q, req_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              wdrawn_q, wdrawn_d;
   logic [PTR_W-1:0]  win_s;
   logic              win_vld_s;

   function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
      if (idx == PTR_W'(N_REQ - 1)) begin
         next_idx = {PTR_W{1'b0}};
      end else begin
         next_idx = idx + PTR_W'(1);
      end
   endfunction

   // First requester at or after ptr, wrapping once around
   always_comb begin
      logic [PTR_W-1:0] idx;
      win_vld_s = 1'b0;
      win_s     = ptr_q;
      idx       = ptr_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_vld_s && bus.req_i[idx]) begin
            win_vld_s = 1'b1;
            win_s     = idx;
         end else begin
            win_s     = win_s;
         end
         idx = next_idx(idx);
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      req_d    = req_q;
      ack_d    = ack_q;
      grant_d  = grant_q;
      data_d   = data_q;
      err_d    = 1'b0;
      wdrawn_d = wdrawn_q;
      case (state_q)
         ST_IDLE: begin
            if (win_vld_s) begin
               gnt_d          = win_s;
               data_d         = bus.data_i[win_s*DATA_W +: DATA_W];
               grant_d        = {N_REQ{1'b0}};
               grant_d[win_s] = 1'b1;
               req_d          = 1'b1;
               wdrawn_d       = 1'b0;
               state_d        = ST_REQ;
            end else begin
               req_d          = 1'b0;
            end
         end
         ST_REQ: begin
            // err flags only the first sampled withdrawal of this transaction
            if (!bus.req_i[gnt_q] && !wdrawn_q) begin
               err_d    = 1'b1;
               wdrawn_d = 1'b1;
            end else begin
               err_d    = 1'b0;
            end
            if (bus.ack_o) begin
               ack_d[gnt_q] = 1'b1;
               state_d      = ST_ACK;
            end else begin
               state_d      = ST_REQ;
            end
         end
         ST_ACK: begin
            if (!bus.req_i[gnt_q]) begin
               req_d   = 1'b0;
               ack_d   = {N_REQ{1'b0}};
               state_d = ST_RET;
            end else begin
               state_d = ST_ACK;
            end
         end
         ST_RET: begin
            if (!bus.ack_o) begin
               grant_d = {N_REQ{1'b0}};
               ptr_d   = next_idx(gnt_q);
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RET;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            ack_d   = {N_REQ{1'b0}};
            grant_d = {N_REQ{1'b0}};
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ptr_q    <= {PTR_W{1'b0}};
         gnt_q    <= {PTR_W{1'b0}};
         req_q    <= 1'b0;
         ack_q    <= {N_REQ{1'b0}};
         grant_q  <= {N_REQ{1'b0}};
         data_q   <= {DATA_W{1'b0}};
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         wdrawn_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         req_q    <= req_d;
         ack_q    <= ack_d;
         grant_q  <= grant_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         wdrawn_q <= wdrawn_d;
      end
   end

   assign bus.req_o   = req_q;
   assign bus.ack_i   = ack_q;
   assign bus.grant_o = grant_q;
   assign bus.data_o  = data_q;
   assign bus.busy_o  = busy_q;
   assign bus.err_o   = err_q;
endmodule

// File: doc/handshake_rr_arbiter.md
Name: handshake_rr_arbiter

Overview:
- Shares one downstream 4-phase req/ack pipeline channel (the input side of a pipeline-stage handshake controller) between N_REQ upstream requesters, each with its own 4-phase channel.
- Arbitration is round-robin. The winner's data word is latched and held stable on the shared data bus for the whole transaction.
- Each upstream handshake completes only after the downstream handshake has completed.

Parameters:
- N_REQ, 4: number of requester channels (>=1).
- DATA_W, 32: data word width per channel.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  N_REQ  per-requester 4-phase request; data_i slice stable while high.
- ack_i  out  N_REQ  per-requester 4-phase acknowledge.
- data_i  in  N_REQ*DATA_W  requester k data at bits [k*DATA_W +: DATA_W].
- req_o  out  1  downstream request.
- ack_o  in  1  downstream acknowledge.
- data_o  out  DATA_W  latched winner data, valid while req_o high.
- grant_o  out  N_REQ  one-hot index of current owner; 0 when idle.
- busy_o  out  1  high in any state except IDLE.
- err_o  out  1  one-cycle pulse on requester protocol violation.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, ptr=0.
  - req_o=0, ack_i=0, data_o=0, grant_o=0, busy_o=0, err_o=0.
  - Asserting rst mid-transaction aborts it. Outputs are zero from the first post-reset cycle, with no completion of the pending handshake.
- All outputs are registered.
- IDLE:
  - If any req_i bit is high, the winner is the first set bit scanning ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1.
  - Latch gnt=winner, data_o=data_i[winner], grant_o=1<<winner. Assert req_o. Go to REQ.
  - ack_o is ignored in IDLE.
- Latency: req_i[k] high at edge t (arbiter idle, k wins) -> req_o=1 and grant_o valid after edge t.
- REQ:
  - Hold req_o=1.
  - On ack_o=1: set ack_i[gnt]=1, go to ACK.
  - If req_i[gnt] is sampled 0 in REQ (early withdrawal): pulse err_o for one cycle. The transaction still proceeds.
- ACK:
  - Hold req_o=1 and ack_i[gnt]=1.
  - On req_i[gnt]=0: clear req_o and ack_i[gnt], go to RET.
  - An early-withdrawn request therefore leaves ACK one cycle after entry.
- RET:
  - Hold req_o=0.
  - On ack_o=0: grant_o=0, ptr=(gnt+1) mod N_REQ, go to IDLE.
- Re-arbitration:
  - A new arbitration happens no sooner than the edge after IDLE is re-entered.
  - Minimum transaction length is 4 cycles.
- Other requesters:
  - ack_i bits of non-owners stay 0 at all times.
  - Their req_i may rise or fall freely while not granted, with no effect.
- data_o holds until the next grant. data_i changes during a transaction do not affect data_o.
- ptr wraps from N_REQ-1 to 0. With N_REQ=1, ptr stays 0.
- ack_o toggling outside the expected state is ignored: high in IDLE or ACK, low in REQ.

Test Plan:
- Single request, N_REQ=4:
  - Stimulus: req_i=0010, data_i[1]=0xA5A5_0001, downstream acks 2 cycles after req_o.
  - Response: grant_o=0010, data_o=0xA5A5_0001.
  - ack_i[1] rises the cycle after ack_o=1 is sampled. Full 4-phase completes. ptr=2.
- All four requesters held high continuously (re-raise immediately after each ack_i falls):
  - Grant order 0,1,2,3,0.
  - grant_o is never multi-hot. ack_i is never multi-hot.
- ptr=3 with req_i=1001: grants 3 then 0 (wrap). Next arbitration with req_i=1001 grants 3.
- Early withdrawal:
  - Stimulus: owner drops req_i while in REQ.
  - Response: err_o single-cycle pulse. After ack_o=1, ACK exits in 1 cycle. req_o falls. Returns to IDLE once ack_o=0.
- Reset mid-transaction:
  - Stimulus: rst asserted while in ACK, with req_o=1 and ack_i[2]=1.
  - Response: next cycle all outputs 0 and state IDLE. After release with req_i=0100, grants 2 with ptr=0 scan order.
- Spurious ack: ack_o=1 while IDLE with req_i=0 produces no output change. Upstream data_i changes in REQ do not alter data_o.
